// File: rtl/bram_frame_reader_if.sv
// Bundles the BRAM read port and the downstream pixel stream of the frame reader.
// The master side is the reader; the slave side is the BRAM plus the pixel consumer.
interface bram_frame_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_BITS  = 17
);
    logic                  ram_enable;
    logic                  ram_write_enable;
    logic [ADDR_BITS-1:0]  ram_address;
    logic [DATA_WIDTH-1:0] ram_data;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic                  pix_eol;
    logic                  pix_eof;

    modport master (
        output ram_enable, ram_write_enable, ram_address,
        output pix_data, pix_valid, pix_eol, pix_eof,
        input  ram_data, pix_ready
    );

    modport slave (
        input  ram_enable, ram_write_enable, ram_address,
        input  pix_data, pix_valid, pix_eol, pix_eof,
        output ram_data, pix_ready
    );
endinterface

// File: rtl/bram_frame_reader.sv
// Raster-order frame reader for a single-port BRAM with one-cycle read latency,
// streaming pixels through a 2-entry buffer onto a valid/ready interface.
module bram_frame_reader #(
    parameter int                   DATA_WIDTH = 16,
    parameter int                   ADDR_BITS  = 17,
    parameter int                   IMG_WIDTH  = 256,
    parameter int                   IMG_HEIGHT = 256,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR  = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    bram_frame_reader_if.master    bus
);
    localparam int COL_BITS = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_BITS = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int EW       = DATA_WIDTH + 2;
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_WIDTH - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(IMG_HEIGHT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [COL_BITS-1:0]  col_q, col_d;
    logic [ROW_BITS-1:0]  row_q, row_d;
    logic                 inflight_q, inflight_d;
    logic [1:0]           tag_q, tag_d;
    logic [EW-1:0]        buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]           count_q, count_d;
    logic                 done_q, done_d;

    logic       issue, pop, lastCol, lastRow;
    logic [1:0] occupancy, fill;

    // Buffer entries are {eof, eol, data}; occupancy counts buffered plus in-flight words.
    always_comb begin
        pop       = (count_q != 2'd0) && bus.pix_ready;
        occupancy = count_q + {1'b0, inflight_q} - {1'b0, pop};
        issue     = (state_q == ST_RUN) && (occupancy < 2'd2);
        lastCol   = (col_q == LAST_COL);
        lastRow   = (row_q == LAST_ROW);

        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (pop) begin
            buf0_d = buf1_q;
        end
        fill = count_q - {1'b0, pop};
        if (inflight_q) begin
            if (fill == 2'd0) begin
                buf0_d = {tag_q, bus.ram_data};
            end else begin
                buf1_d = {tag_q, bus.ram_data};
            end
        end
        count_d = fill + {1'b0, inflight_q};

        addr_d     = addr_q;
        col_d      = col_q;
        row_d      = row_q;
        inflight_d = issue;
        tag_d      = tag_q;
        if (issue) begin
            addr_d = addr_q + ADDR_BITS'(1);
            col_d  = lastCol ? '0 : col_q + COL_BITS'(1);
            if (lastCol) begin
                row_d = row_q + ROW_BITS'(1);
            end
            tag_d = {lastCol && lastRow, lastCol};
        end

        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    addr_d  = BASE_ADDR;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_RUN: begin
                if (issue && lastCol && lastRow) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave once the final word has landed and been handed downstream.
                if ((count_d == 2'd0) && !inflight_d) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= BASE_ADDR;
            col_q      <= '0;
            row_q      <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            count_q    <= count_d;
            done_q     <= done_d;
        end
    end

    assign busy                 = (state_q != ST_IDLE);
    assign done                 = done_q;
    assign bus.ram_enable       = issue;
    assign bus.ram_write_enable = 1'b0;
    assign bus.ram_address      = addr_q;
    assign bus.pix_valid        = (count_q != 2'd0);
    assign bus.pix_data         = buf0_q[DATA_WIDTH-1:0];
    assign bus.pix_eol          = bus.pix_valid && buf0_q[DATA_WIDTH];
    assign bus.pix_eof          = bus.pix_valid && buf0_q[DATA_WIDTH+1];
endmodule

// File: tb/tb_bram_frame_reader.sv
// Directed bench for bram_frame_reader: a 4x3 frame at 0x10 and a 4x1 frame straddling the address wrap.
module tb_bram_frame_reader;
    logic clock;
    logic reset;
    logic start, busy, done, pixReady;
    logic start2, busy2, done2;
    int   passCount;
    int   totalCount;

    bram_frame_reader_if #(.DATA_WIDTH(16), .ADDR_BITS(17)) bus1 ();
    bram_frame_reader_if #(.DATA_WIDTH(16), .ADDR_BITS(17)) bus2 ();

    bram_frame_reader #(
        .DATA_WIDTH(16), .ADDR_BITS(17), .IMG_WIDTH(4), .IMG_HEIGHT(3), .BASE_ADDR(17'h00010)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done), .bus(bus1.master)
    );

    bram_frame_reader #(
        .DATA_WIDTH(16), .ADDR_BITS(17), .IMG_WIDTH(4), .IMG_HEIGHT(1), .BASE_ADDR(17'h1FFFE)
    ) dutWrap (
        .clock(clock), .reset(reset), .start(start2), .busy(busy2), .done(done2), .bus(bus2.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // BRAM models: registered read, each word holds its own address.
    always_ff @(posedge clock) begin
        if (bus1.ram_enable) bus1.ram_data <= bus1.ram_address[15:0];
        if (bus2.ram_enable) bus2.ram_data <= bus2.ram_address[15:0];
    end
    assign bus1.pix_ready = pixReady;
    assign bus2.pix_ready = 1'b1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic st, input logic rdy, input logic rst);
        @(negedge clock);
        start    = st;
        pixReady = rdy;
        reset    = rst;
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"},  busy, 0);
        checkOutput({tag, "_done"},  done, 0);
        checkOutput({tag, "_valid"}, bus1.pix_valid, 0);
        checkOutput({tag, "_data"},  bus1.pix_data, 0);
        checkOutput({tag, "_eol"},   bus1.pix_eol, 0);
        checkOutput({tag, "_eof"},   bus1.pix_eof, 0);
        checkOutput({tag, "_ren"},   bus1.ram_enable, 0);
        checkOutput({tag, "_addr"},  bus1.ram_address, 32'h10);
    endtask

    // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: ready low for 20 cycles.
    task automatic runFrame(input string tag, input int mode, input int startAgain);
        int issued = 0;
        int popped = 0;
        int lastPop = -10;
        int finished = 0;
        int popNow;
        logic rdy;
        logic prevStall = 1'b0;
        logic [15:0] prevData = '0;
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int cyc = 1; cyc <= 200 && finished == 0; cyc++) begin
            case (mode)
                1:       rdy = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
                2:       rdy = (cyc > 20);
                default: rdy = 1'b1;
            endcase
            applyStimulus(cyc == startAgain, rdy, 1'b0);
            popNow = (bus1.pix_valid && rdy) ? 1 : 0;
            checkOutput($sformatf("%s_ren_c%0d", tag, cyc), bus1.ram_enable,
                        (issued < 12) && ((issued - popped - popNow) < 2));
            if (bus1.ram_enable) begin
                checkOutput($sformatf("%s_addr_c%0d", tag, cyc), bus1.ram_address, 32'h10 + issued);
                issued++;
            end
            if (prevStall) begin
                checkOutput($sformatf("%s_holdv_c%0d", tag, cyc), bus1.pix_valid, 1);
                checkOutput($sformatf("%s_holdd_c%0d", tag, cyc), bus1.pix_data, prevData);
            end
            if (bus1.pix_valid) begin
                checkOutput($sformatf("%s_data_c%0d", tag, cyc), bus1.pix_data, 32'h10 + popped);
            end
            checkOutput($sformatf("%s_eol_c%0d", tag, cyc), bus1.pix_eol, bus1.pix_valid && ((popped % 4) == 3));
            checkOutput($sformatf("%s_eof_c%0d", tag, cyc), bus1.pix_eof, bus1.pix_valid && (popped == 11));
            checkOutput($sformatf("%s_busy_c%0d", tag, cyc), busy, !done);
            if (popNow != 0) begin
                popped++;
                lastPop = cyc;
            end
            if (done) begin
                checkOutput({tag, "_done_count"}, popped, 12);
                checkOutput({tag, "_done_cycle"}, cyc, lastPop + 1);
                finished = 1;
            end
            if (mode == 2 && cyc == 20) begin
                checkOutput({tag, "_stall_reads"}, issued, 2);
                checkOutput({tag, "_stall_pops"}, popped, 0);
            end
            prevStall = bus1.pix_valid && !rdy;
            prevData  = bus1.pix_data;
        end
        checkOutput({tag, "_finished"}, finished, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput({tag, "_after_done"}, done, 0);
            checkOutput({tag, "_after_busy"}, busy, 0);
            checkOutput({tag, "_after_ren"}, bus1.ram_enable, 0);
        end
    endtask

    initial begin
        logic [16:0] wrapAddr [4] = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
        logic [15:0] wrapData [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        passCount  = 0;
        totalCount = 0;
        start      = 1'b0;
        start2     = 1'b0;
        pixReady   = 1'b1;
        reset      = 1'b1;

        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkResetState("reset");
        checkOutput("reset_we", bus1.ram_write_enable, 0);

        // Frame A at full rate, restarted on its done cycle.
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            applyStimulus(c == 15, 1'b1, 1'b0);
            checkOutput($sformatf("a_busy_c%0d", c), busy, (c <= 14) || (c == 16));
            checkOutput($sformatf("a_done_c%0d", c), done, c == 15);
            checkOutput($sformatf("a_ren_c%0d", c), bus1.ram_enable, (c <= 12) || (c == 16));
            if (c <= 12) checkOutput($sformatf("a_addr_c%0d", c), bus1.ram_address, 32'h10 + c - 1);
            if (c == 16) checkOutput("a_restart_addr", bus1.ram_address, 32'h10);
            checkOutput($sformatf("a_valid_c%0d", c), bus1.pix_valid, (c >= 3) && (c <= 14));
            if (c >= 3 && c <= 14) begin
                checkOutput($sformatf("a_data_c%0d", c), bus1.pix_data, 32'h10 + c - 3);
                checkOutput($sformatf("a_eol_c%0d", c), bus1.pix_eol, ((c - 3) % 4) == 3);
                checkOutput($sformatf("a_eof_c%0d", c), bus1.pix_eof, c == 14);
            end
            checkOutput($sformatf("a_we_c%0d", c), bus1.ram_write_enable, 0);
        end

        // Frame B aborted by reset in its eighth cycle.
        for (int c = 17; c <= 23; c++) applyStimulus(1'b0, 1'b1, c == 23);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkResetState("abort");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("abort_no_done", done, 0);
            checkOutput("abort_idle", busy, 0);
        end

        runFrame("replay", 0, 5);
        runFrame("toggle", 1, -1);
        runFrame("stall", 2, -1);

        // Address wrap across the top of the BRAM.
        @(negedge clock);
        start2 = 1'b1;
        #1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            start2 = 1'b0;
            #1;
            checkOutput($sformatf("w_ren_c%0d", c), bus2.ram_enable, c <= 4);
            if (c <= 4) checkOutput($sformatf("w_addr_c%0d", c), bus2.ram_address, wrapAddr[c-1]);
            checkOutput($sformatf("w_valid_c%0d", c), bus2.pix_valid, (c >= 3) && (c <= 6));
            if (c >= 3 && c <= 6) checkOutput($sformatf("w_data_c%0d", c), bus2.pix_data, wrapData[c-3]);
            checkOutput($sformatf("w_eol_c%0d", c), bus2.pix_eol, c == 6);
            checkOutput($sformatf("w_eof_c%0d", c), bus2.pix_eof, c == 6);
            checkOutput($sformatf("w_done_c%0d", c), done2, c == 7);
            checkOutput($sformatf("w_busy_c%0d", c), busy2, c <= 6);
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end
endmodule

// File: doc/bram_frame_reader.md
Name: bram_frame_reader

Overview:
- Read-side master for the single-port image BRAM: on `start`, scans a stored frame in raster order starting at BASE_ADDR.
- Streams the pixels out on a valid/ready interface to downstream filter stages.
- Absorbs the BRAM's one-cycle registered read latency and any downstream backpressure with a 2-entry output buffer, so throughput is one pixel per clock when `pix_ready` is held high.

Parameters:
- DATA_WIDTH, 16, pixel/word width; must equal the BRAM RAM_WIDTH.
- ADDR_BITS, 17, BRAM address width.
- IMG_WIDTH, 256, pixels per line (≥1).
- IMG_HEIGHT, 256, lines per frame (≥1).
- BASE_ADDR, 0, BRAM address of pixel (0,0).

Ports:
- clock, input, 1, sole clock; all logic on posedge.
- reset, input, 1, synchronous, active-high.
- start, input, 1, begin frame read; sampled only in IDLE.
- busy, output, 1, high from the cycle after `start` is accepted until `done`.
- done, output, 1, one-cycle pulse after the last pixel handshake.
- ram_enable, output, 1, BRAM enable; high only on cycles a read is issued.
- ram_write_enable, output, 1, tied 0.
- ram_address, output, ADDR_BITS, BRAM read address.
- ram_data, input, DATA_WIDTH, BRAM output_data; valid the cycle after the read is issued.
- pix_data, output, DATA_WIDTH, pixel value.
- pix_valid, output, 1, pixel available.
- pix_ready, input, 1, downstream accepts the pixel.
- pix_eol, output, 1, qualifies pix_data as the last pixel of a line.
- pix_eof, output, 1, qualifies pix_data as the last pixel of the frame.

Behaviour:
- Clock, reset and interface
  - Clock `clock`. Reset `reset` is synchronous and active-high.
  - `reset` forces, at the next edge: state IDLE; buffers and in-flight flag cleared; busy=0, done=0, pix_valid=0, pix_eol=0, pix_eof=0, pix_data=0, ram_enable=0, ram_address=BASE_ADDR.
  - Reset mid-frame aborts the read: the partial frame is discarded and no `done` is issued.
- States
  - IDLE: `start`=1 → RUN, issue counter=0.
  - RUN: issues reads; after read number IMG_WIDTH*IMG_HEIGHT is issued → DRAIN.
  - DRAIN: waits until the in-flight read has landed and the buffer is empty → IDLE, with done=1 for exactly that one cycle.
  - `start` is ignored in RUN and DRAIN.
- Read issue (RUN only)
  - ram_enable is combinational: (state==RUN) && (buffered + inflight − pop < 2), where pop = pix_valid && pix_ready in the same cycle.
  - ram_address = BASE_ADDR + issue counter. The counter increments on each issue; the width is ADDR_BITS and the address wraps modulo 2^ADDR_BITS.
  - ram_write_enable is always 0.
- Capture
  - A read issued in cycle t sets the inflight flag; ram_data is written into the buffer at the end of cycle t+1.
  - eol/eof tags travel with each entry, computed from the column and row counters at issue time.
  - eol = (col == IMG_WIDTH−1); eof = eol && (row == IMG_HEIGHT−1).
- Output
  - pix_* are driven from the buffer head, so pix_data, eol and eof are stable while pix_valid=1 and pix_ready=0.
  - Pop and capture in the same cycle are both honoured.
  - The buffer never overflows, by the issue rule above.
- Latency
  - `start` in cycle 0 → ram_enable=1 with address BASE_ADDR in cycle 1 → pix_valid=1 in cycle 3.
  - With pix_ready held high, there is one pixel per cycle thereafter with no bubbles.
- done
  - Asserted the cycle after the eof pixel is accepted; busy falls in that same cycle.
  - A new `start` is accepted on the cycle done is high (state is IDLE by then).
- Degenerate frame
  - IMG_WIDTH=IMG_HEIGHT=1: a single pixel is output with eol=eof=1.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=3, BASE_ADDR=0x10, BRAM preloaded with word = address, pix_ready=1, start pulse at cycle 0 → ram_enable first high in cycle 1 at 0x10; pix_data 0x10..0x1B on cycles 3..14; eol on 0x13, 0x17, 0x1B; eof only on 0x1B; done=1 in cycle 15; busy high cycles 1–14.
- Same frame, pix_ready toggled 1,0,0,1 repeating → all 12 pixels delivered in order, no duplicates or drops; pix_data held stable while stalled; ram_enable never issues when buffered+inflight=2.
- pix_ready=0 for 20 cycles after start, then 1 → exactly 2 reads issued during the stall (addresses 0x10, 0x11); output resumes at 0x10; done after the 12th handshake.
- `start` pulsed again in RUN at cycle 5 → ignored; only one done; then start on the done cycle → second frame begins; ram_enable=1 at 0x10 the next cycle.
- reset asserted at cycle 8 mid-frame → next cycle all outputs at reset values, no done; following start replays from 0x10 correctly.
- BASE_ADDR=2^17−2, IMG_WIDTH=4, IMG_HEIGHT=1 → addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001; eol=eof on the fourth pixel.
